// File: rtl/memory_access_sb.sv
// memory_access_sb
// Memory-stage unit with a store buffer in front of an external data memory.
// Stores are posted into a circular buffer. The buffer drains one entry at a
// time over a req/ack port. Load misses use the same port with variable
// latency. Only one memory transaction is in flight at any time.
//
// Optional feature macro: MEM_SB_LOAD_FWD_EN
//   defined   : a load whose address matches a buffered store gets that data
//               straight from the buffer. If several entries match, the
//               youngest one wins.
//   undefined : there is no address compare. A load waits until the buffer
//               is empty and then reads memory.
//
// Ports
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   op_valid/op_load/op_store
//                       memory op handshake; fields are held while stall=1
//   ra_sel, wa_sel      load/store address source (0=ra_pipe, 1=alu_out)
//   ra_pipe, alu_out    address sources
//   din_sel, fwd_sel    store data base (rf_out1/rf_out2) and forward override
//   rf_out1, rf_out2, sig_b, sig_c, sig_z
//                       store data sources
//   mem_data            load result, valid while a load sees stall=0
//   ra_inc              ra_pipe + 1
//   stall               hold the pipeline (combinational)
//   mem_req/mem_we/mem_addr/mem_wdata
//                       registered memory request, held until ack
//   mem_ack, mem_rdata  memory completion and read data
module memory_access_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int SB_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic              op_load,
    input  logic              op_store,
    input  logic              ra_sel,
    input  logic              wa_sel,
    input  logic [DATA_W-1:0] ra_pipe,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              din_sel,
    input  logic [1:0]        fwd_sel,
    input  logic [DATA_W-1:0] rf_out1,
    input  logic [DATA_W-1:0] rf_out2,
    input  logic [DATA_W-1:0] sig_b,
    input  logic [DATA_W-1:0] sig_c,
    input  logic [DATA_W-1:0] sig_z,
    output logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] ra_inc,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        RDONE = 2'd2,
        WR    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] sbAddr_q [SB_DEPTH];
    logic [DATA_W-1:0] sbData_q [SB_DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] lastData_q, lastData_d;
    logic              memReq_q, memReq_d;
    logic              memWe_q, memWe_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;

    logic [DATA_W-1:0] loadSrc, storeSrc, storeBase, storeData;
    logic [ADDR_W-1:0] loadAddr, storeAddr;
    logic              sbFull, storeReq, push, pop;
    logic              loadReq, loadHit, loadMiss, rdAllowed;
    logic [DATA_W-1:0] hitData, memDataOut;

    // Addresses are the low ADDR_W bits of the selected source.
    assign loadSrc   = ra_sel ? alu_out : ra_pipe;
    assign storeSrc  = wa_sel ? alu_out : ra_pipe;
    assign loadAddr  = loadSrc[ADDR_W-1:0];
    assign storeAddr = storeSrc[ADDR_W-1:0];
    assign storeBase = din_sel ? rf_out2 : rf_out1;

    // Store data: register-file base unless a forwarded value overrides it.
    always_comb begin
        storeData = storeBase;
        case (fwd_sel)
            2'd1:    storeData = sig_b;
            2'd2:    storeData = sig_c;
            2'd3:    storeData = sig_z;
            default: storeData = storeBase;
        endcase
    end

    // A full buffer blocks the push even if an entry pops in the same cycle.
    // The stalled store is therefore accepted one cycle after the pop.
    assign sbFull   = (count_q == CNT_W'(SB_DEPTH));
    assign storeReq = op_valid & op_store;
    assign push     = storeReq & ~sbFull;
    // In RDONE the op on the inputs is the load that is completing, so it
    // must not be evaluated again.
    assign loadReq  = op_valid & op_load & (state_q != RDONE);

`ifdef MEM_SB_LOAD_FWD_EN
    logic sbHit;

    // Walk the valid entries from oldest to youngest, so the last match
    // found is the youngest store. Entries still draining take part,
    // because an entry leaves the buffer only on its ack.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx     = '0;
        sbHit   = 1'b0;
        hitData = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (sbAddr_q[idx] == loadAddr)) begin
                sbHit   = 1'b1;
                hitData = sbData_q[idx];
            end
        end
    end

    assign loadHit   = loadReq & sbHit;
    assign loadMiss  = loadReq & ~sbHit;
    assign rdAllowed = 1'b1;
`else
    // Strict ordering: every load goes to memory, and only once the buffer
    // is empty.
    assign loadHit   = 1'b0;
    assign hitData   = '0;
    assign loadMiss  = loadReq;
    assign rdAllowed = (count_q == '0);
`endif

    // Transaction FSM and buffer bookkeeping. A load miss takes priority
    // over draining. A miss seen during WR waits for the ack there and then
    // issues from IDLE.
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        rdata_d    = rdata_q;
        memReq_d   = memReq_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (loadMiss && rdAllowed) begin
                    state_d   = RD;
                    memReq_d  = 1'b1;
                    memWe_d   = 1'b0;
                    memAddr_d = loadAddr;
                end else if (count_q != '0) begin
                    state_d    = WR;
                    memReq_d   = 1'b1;
                    memWe_d    = 1'b1;
                    memAddr_d  = sbAddr_q[head_q];
                    memWdata_d = sbData_q[head_q];
                end
            end
            RD: begin
                if (mem_ack) begin
                    rdata_d  = mem_rdata;
                    memReq_d = 1'b0;
                    state_d  = RDONE;
                end
            end
            RDONE: begin
                state_d = IDLE;
            end
            WR: begin
                if (mem_ack) begin
                    pop      = 1'b1;
                    memReq_d = 1'b0;
                    memWe_d  = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Only an outstanding read stalls unconditionally. Otherwise the stall
    // comes from a load that has to go to memory or a store into a full
    // buffer.
    always_comb begin
        stall = 1'b0;
        case (state_q)
            RD:      stall = 1'b1;
            RDONE:   stall = 1'b0;
            default: stall = loadMiss | (storeReq & sbFull);
        endcase
    end

    // mem_data keeps its last value whenever no load is completing.
    always_comb begin
        memDataOut = lastData_q;
        if (state_q == RDONE) begin
            memDataOut = rdata_q;
        end else if (loadHit) begin
            memDataOut = hitData;
        end
    end

    assign lastData_d = memDataOut;

    // Control registers. Reset drops any request immediately and discards
    // the buffered stores by clearing the pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rdata_q    <= '0;
            lastData_q <= '0;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rdata_q    <= rdata_d;
            lastData_q <= lastData_d;
            memReq_q   <= memReq_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
        end
    end

    // Buffer storage needs no reset. Validity comes only from head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            sbAddr_q[tail_q] <= storeAddr;
            sbData_q[tail_q] <= storeData;
        end
    end

    assign mem_data  = memDataOut;
    assign ra_inc    = ra_pipe + DATA_W'(1);
    assign mem_req   = memReq_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;

endmodule

// File: tb/tb_memory_access_sb.sv
// tb_memory_access_sb
// Directed bench for memory_access_sb. Inputs are driven 1 time unit after
// the rising edge. Outputs are sampled 4 units later, at the falling edge.
// Expectations that depend on MEM_SB_LOAD_FWD_EN are selected with the same
// macro.
module tb_memory_access_sb;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 16;
    localparam int SB_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              op_valid, op_load, op_store;
    logic              ra_sel, wa_sel, din_sel;
    logic [1:0]        fwd_sel;
    logic [DATA_W-1:0] ra_pipe, alu_out;
    logic [DATA_W-1:0] rf_out1, rf_out2, sig_b, sig_c, sig_z;
    logic [DATA_W-1:0] mem_data, ra_inc, mem_wdata, mem_rdata;
    logic              stall, mem_req, mem_we, mem_ack;
    logic [ADDR_W-1:0] mem_addr;

    int                compared   = 0;
    int                mismatched = 0;
    logic [DATA_W-1:0] drained[$];

    int                cycles;
    logic              sawRead;
    logic [ADDR_W-1:0] readAddr;

    memory_access_sb #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .SB_DEPTH(SB_DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op_load  (op_load),
        .op_store (op_store),
        .ra_sel   (ra_sel),
        .wa_sel   (wa_sel),
        .ra_pipe  (ra_pipe),
        .alu_out  (alu_out),
        .din_sel  (din_sel),
        .fwd_sel  (fwd_sel),
        .rf_out1  (rf_out1),
        .rf_out2  (rf_out2),
        .sig_b    (sig_b),
        .sig_c    (sig_c),
        .sig_z    (sig_z),
        .mem_data (mem_data),
        .ra_inc   (ra_inc),
        .stall    (stall),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Hard stop in case a bounded loop is broken.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic load, input logic store,
                                 input logic raSel, input logic waSel,
                                 input logic [15:0] raPipe, input logic [15:0] aluOut,
                                 input logic dinSel, input logic [1:0] fwdSel);
        op_valid = valid;
        op_load  = load;
        op_store = store;
        ra_sel   = raSel;
        wa_sel   = waSel;
        ra_pipe  = raPipe;
        alu_out  = aluOut;
        din_sel  = dinSel;
        fwd_sel  = fwdSel;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    // Single store into an empty buffer, then its drain acked on the first
    // write cycle.
    task automatic storeAndDrain(input string tag, input logic waSel,
                                 input logic [15:0] raPipe, input logic [15:0] aluOut,
                                 input logic dinSel, input logic [1:0] fwdSel,
                                 input logic [15:0] expAddr, input logic [15:0] expData);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, waSel, raPipe, aluOut, dinSel, fwdSel);
        settle();
        checkOutput({tag, "_stall"}, stall, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 2'd0);
        settle();
        checkOutput({tag, "_count"}, dut.count_q, 1);
        tick();
        mem_ack = 1'b1;
        settle();
        checkOutput({tag, "_req"}, mem_req, 1'b1);
        checkOutput({tag, "_we"}, mem_we, 1'b1);
        checkOutput({tag, "_addr"}, mem_addr, expAddr);
        checkOutput({tag, "_wdata"}, mem_wdata, expData);
        tick();
        mem_ack = 1'b0;
        settle();
        checkOutput({tag, "_empty"}, dut.count_q, 0);
        tick();
    endtask

    // Hold the current load, acking any request at once, until stall drops.
    // The loop ends at a sample point.
    task automatic waitLoad(input logic [15:0] rdata);
        logic done;
        done     = 1'b0;
        cycles   = 0;
        sawRead  = 1'b0;
        readAddr = '0;
        mem_rdata = rdata;
        while (!done) begin
            mem_ack = mem_req;
            if (mem_req && !mem_we) begin
                sawRead  = 1'b1;
                readAddr = mem_addr;
            end
            settle();
            if (!stall || cycles >= 30) begin
                done = 1'b1;
            end else begin
                tick();
                cycles++;
            end
        end
    endtask

    // Ack every request until the buffer is empty, recording the drained
    // data.
    task automatic drainAll(input string tag);
        int n;
        n = 0;
        drained.delete();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 2'd0);
        while ((dut.count_q != 0 || mem_req) && n < 40) begin
            mem_ack = mem_req;
            if (mem_req && mem_we) begin
                drained.push_back(mem_wdata);
            end
            tick();
            n++;
        end
        mem_ack = 1'b0;
        settle();
        checkOutput({tag, "_drain_bounded"}, (n < 40), 1'b1);
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        rf_out1   = 16'hA001;
        rf_out2   = 16'hA002;
        sig_b     = 16'hB00B;
        sig_c     = 16'hC00C;
        sig_z     = 16'hD00D;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 2'd0);
        tick();
        tick();
        settle();
        checkOutput("rst_req", mem_req, 1'b0);
        checkOutput("rst_we", mem_we, 1'b0);
        checkOutput("rst_stall", stall, 1'b0);
        checkOutput("rst_mem_data", mem_data, 16'h0000);
        checkOutput("rst_count", dut.count_q, 0);
        tick();
        reset = 1'b0;

        // Load miss from alu_out, acked on the second request cycle.
        $display("[TB] load miss with delayed ack");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0040, 1'b0, 2'd0);
        settle();
        checkOutput("miss_c0_stall", stall, 1'b1);
        checkOutput("miss_c0_req", mem_req, 1'b0);
        checkOutput("ra_inc_1234", ra_inc, 16'h1235);
        tick();
        settle();
        checkOutput("miss_c1_stall", stall, 1'b1);
        checkOutput("miss_c1_req", mem_req, 1'b1);
        checkOutput("miss_c1_we", mem_we, 1'b0);
        checkOutput("miss_c1_addr", mem_addr, 16'h0040);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        settle();
        checkOutput("miss_c2_stall", stall, 1'b1);
        tick();
        mem_ack = 1'b0;
        settle();
        checkOutput("miss_c3_stall", stall, 1'b0);
        checkOutput("miss_c3_data", mem_data, 16'hBEEF);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 2'd0);
        mem_rdata = '0;
        settle();
        checkOutput("idle_hold_data", mem_data, 16'hBEEF);
        checkOutput("idle_stall", stall, 1'b0);
        checkOutput("idle_req", mem_req, 1'b0);
        tick();

        // Store data and address selection seen on the drain port.
        $display("[TB] store data selection");
        storeAndDrain("st_rf1", 1'b1, 16'h0000, 16'h0100, 1'b0, 2'd0, 16'h0100, 16'hA001);
        storeAndDrain("st_rf2", 1'b0, 16'h0200, 16'h0000, 1'b1, 2'd0, 16'h0200, 16'hA002);
        storeAndDrain("st_b", 1'b1, 16'h0000, 16'h0101, 1'b1, 2'd1, 16'h0101, 16'hB00B);
        storeAndDrain("st_c", 1'b1, 16'h0000, 16'h0102, 1'b1, 2'd2, 16'h0102, 16'hC00C);
        storeAndDrain("st_z", 1'b1, 16'h0000, 16'h0103, 1'b1, 2'd3, 16'h0103, 16'hD00D);

        // Store then load to the same address before the drain completes.
        $display("[TB] store then load same address");
        rf_out1 = 16'h1234;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0010, 1'b0, 2'd0);
        settle();
        checkOutput("sl_store_stall", stall, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 2'd0);
        waitLoad(16'h1234);
        checkOutput("sl_data", mem_data, 16'h1234);
`ifdef MEM_SB_LOAD_FWD_EN
        checkOutput("sl_cycles", cycles, 0);
        checkOutput("sl_no_read", sawRead, 1'b0);
`else
        checkOutput("sl_cycles", cycles, 4);
        checkOutput("sl_read", sawRead, 1'b1);
        checkOutput("sl_read_addr", readAddr, 16'h0010);
`endif
        tick();
        drainAll("sl");
        rf_out1 = 16'hA001;

        // Two stores to one address; the load must see the younger one.
        $display("[TB] youngest store wins");
        rf_out1 = 16'h1111;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0020, 1'b0, 2'd0);
        settle();
        checkOutput("yw_st1_stall", stall, 1'b0);
        tick();
        rf_out1 = 16'h2222;
        settle();
        checkOutput("yw_st2_stall", stall, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 2'd0);
        waitLoad(16'h2222);
        checkOutput("yw_data", mem_data, 16'h2222);
`ifdef MEM_SB_LOAD_FWD_EN
        checkOutput("yw_cycles", cycles, 0);
        checkOutput("yw_no_read", sawRead, 1'b0);
`else
        checkOutput("yw_cycles", cycles, 5);
        checkOutput("yw_read_addr", readAddr, 16'h0020);
`endif
        tick();
        drainAll("yw");
        rf_out1 = 16'hA001;

        // Fill the buffer with the memory stalled; the fifth store waits.
        $display("[TB] full buffer back-pressure");
        for (int k = 0; k < 4; k++) begin
            rf_out1 = 16'(16'h5000 + k);
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'(16'h0030 + k), 1'b0, 2'd0);
            settle();
            checkOutput($sformatf("fill%0d_stall", k), stall, 1'b0);
            tick();
        end
        rf_out1 = 16'h5004;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0034, 1'b0, 2'd0);
        settle();
        checkOutput("full_stall", stall, 1'b1);
        checkOutput("full_count", dut.count_q, 4);
        tick();
        mem_ack = 1'b1;
        settle();
        checkOutput("full_ack_stall", stall, 1'b1);
        checkOutput("full_ack_wdata", mem_wdata, 16'h5000);
        tick();
        mem_ack = 1'b0;
        settle();
        checkOutput("after_pop_stall", stall, 1'b0);
        checkOutput("after_pop_count", dut.count_q, 3);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 2'd0);
        settle();
        checkOutput("fifth_pushed_count", dut.count_q, 4);
        checkOutput("fifth_pushed_stall", stall, 1'b0);
        tick();
        drainAll("full");
        checkOutput("full_drained_n", drained.size(), 4);
        checkOutput("full_drained_first", drained.size() > 0 ? drained[0] : 16'hxxxx, 16'h5001);
        checkOutput("full_drained_last", drained.size() > 3 ? drained[3] : 16'hxxxx, 16'h5004);

        // Reset in the middle of a transaction with three stores buffered.
        $display("[TB] reset mid-transaction");
        for (int k = 0; k < 4; k++) begin
            rf_out1 = 16'(16'h6000 + k);
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'(16'h0040 + k), 1'b0, 2'd0);
            tick();
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0077, 16'h0000, 1'b0, 2'd0);
        mem_ack = 1'b1;
        settle();
        checkOutput("rmt_c5_stall", stall, 1'b1);
        tick();
        mem_ack = 1'b0;
        settle();
        checkOutput("rmt_c6_stall", stall, 1'b1);
        checkOutput("rmt_c6_count", dut.count_q, 3);
        tick();
        settle();
        checkOutput("rmt_c7_req", mem_req, 1'b1);
`ifdef MEM_SB_LOAD_FWD_EN
        checkOutput("rmt_c7_we", mem_we, 1'b0);
`else
        checkOutput("rmt_c7_we", mem_we, 1'b1);
`endif
        checkOutput("rmt_c7_count", dut.count_q, 3);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 2'd0);
        #1;
        checkOutput("rmt_req", mem_req, 1'b0);
        checkOutput("rmt_count", dut.count_q, 0);
        checkOutput("rmt_stall", stall, 1'b0);
        checkOutput("rmt_mem_data", mem_data, 16'h0000);
        checkOutput("ra_inc_wrap", ra_inc, 16'h0000);
        tick();
        reset = 1'b0;
        settle();
        checkOutput("post_rst_req", mem_req, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
